// File: rtl/mul_pkg.sv
// Shared definitions for the repeated-addition multiplier (controller and datapath).
// Holds the default operand width, the product-width rule and the control bundle.
package mul_pkg;

  localparam int WIDTH_DEF = 32;

  // The product of two w-bit operands always fits in 2*w bits.
  function automatic int pwidth_of(input int w);
    return 2 * w;
  endfunction

  typedef struct packed {
    logic lda;
    logic ldb;
    logic ldp;
    logic clra;
    logic clrp;
    logic decb;
  } mul_ctrl_t;

endpackage

// File: rtl/mul_cntr.sv
// Saturating down-counter with parallel load and zero flag; holds the multiplier B.
// Load has priority over decrement, and a decrement at zero is ignored.
module mul_cntr #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = d_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mul_datapath.sv
// Repeated-addition multiplier datapath: multiplicand A, down-counter B, accumulator P.
// Define MUL_DP_ZSKIP_EN to end early (eq=1, no stepping) when A is zero.
import mul_pkg::*;

module mul_datapath #(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int PWIDTH = pwidth_of(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  datain,
  input  logic              lda,
  input  logic              ldb,
  input  logic              ldp,
  input  logic              clra,
  input  logic              clrp,
  input  logic              decb,
  output logic              eq,
  output logic [PWIDTH-1:0] product,
  output logic [WIDTH-1:0]  a_q
);

  mul_ctrl_t         ctrl;
  logic [WIDTH-1:0]  a_val_q, a_val_d;
  logic [PWIDTH-1:0] p_q, p_d;
  logic              b_zero;
  logic              step_ok;
  logic              dec_en;

  assign ctrl = '{lda: lda, ldb: ldb, ldp: ldp, clra: clra, clrp: clrp, decb: decb};

`ifdef MUL_DP_ZSKIP_EN
  logic a_zero;
  assign a_zero  = (a_val_q == '0);
  assign step_ok = !b_zero && !a_zero;
  assign dec_en  = ctrl.decb && !a_zero;
  assign eq      = b_zero || a_zero;
`else
  assign step_ok = !b_zero;
  assign dec_en  = ctrl.decb;
  assign eq      = b_zero;
`endif

  mul_cntr #(.WIDTH(WIDTH)) u_b_cntr (
    .clk    (clk),
    .rst    (rst),
    .load_i (ctrl.ldb),
    .dec_i  (dec_en),
    .d_i    (datain),
    .zero_o (b_zero)
  );

  always_comb begin
    a_val_d = a_val_q;
    if (ctrl.clra) begin
      a_val_d = '0;
    end else if (ctrl.lda) begin
      a_val_d = datain;
    end
  end

  // ldp stays high in the controller's done state, so accumulation is gated on B.
  always_comb begin
    p_d = p_q;
    if (ctrl.clrp) begin
      p_d = '0;
    end else if (ctrl.ldp && step_ok) begin
      p_d = p_q + {{(PWIDTH-WIDTH){1'b0}}, a_val_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_val_q <= '0;
      p_q     <= '0;
    end else begin
      a_val_q <= a_val_d;
      p_q     <= p_d;
    end
  end

  assign product = p_q;
  assign a_q     = a_val_q;

endmodule
